// File: rtl/mem_wb_forward_pipe.sv
// EX/MEM and MEM/WB pipeline registers feeding the forwarding unit.
// Inserts load-use bubbles, runs the load handshake with data memory,
// freezes upstream stages while a load waits, and abandons hung loads.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   ex_valid/ex_we/ex_wb_sel/ex_rd/ex_result   EX stage instruction
//   stall_in                         load-use stall request
//   mem_rvalid/mem_rdata             data memory read response
//   rd_mem/write_enable_mem/wb_sel_mem/result_mem   MEM stage register
//   rd_wb/write_enable_wb/result_wb  WB stage register
//   mem_req/mem_addr                 load request (combinational)
//   pipe_hold                        freeze PC/IF/ID/EX (combinational)
//   load_error                       sticky load timeout flag
module mem_wb_forward_pipe #(
    parameter int unsigned DATA_W       = 256,
    parameter int unsigned LOAD_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic              ex_we,
    input  logic              ex_wb_sel,
    input  logic [4:0]        ex_rd,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              stall_in,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [4:0]        rd_mem,
    output logic              write_enable_mem,
    output logic              wb_sel_mem,
    output logic [DATA_W-1:0] result_mem,
    output logic [4:0]        rd_wb,
    output logic              write_enable_wb,
    output logic [DATA_W-1:0] result_wb,
    output logic              mem_req,
    output logic [31:0]       mem_addr,
    output logic              pipe_hold,
    output logic              load_error
);

    localparam int unsigned RD_W   = 5;
    localparam int unsigned ADDR_W = 32;
    // Counter only has to reach LOAD_TIMEOUT-1
    localparam int unsigned CNT_W  = (LOAD_TIMEOUT > 2) ? $clog2(LOAD_TIMEOUT) : 1;

    typedef enum logic {ST_RUN, ST_WAIT} state_t;

    typedef struct packed {
        logic [RD_W-1:0]   rd;
        logic              we;
        logic              wb_sel;
        logic [DATA_W-1:0] result;
    } mem_stage_t;

    typedef struct packed {
        logic [RD_W-1:0]   rd;
        logic              we;
        logic [DATA_W-1:0] result;
    } wb_stage_t;

    state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mem_stage_t mem_q, mem_d, ex_stage;
    wb_stage_t  wb_q, wb_d;
    logic       err_q, err_d;
    logic       mem_load;
    logic       timeout;

    // Request and hold are derived from the MEM register and the response
    always_comb begin
        mem_load  = mem_q.we & ~mem_q.wb_sel;
        mem_req   = mem_load;
        mem_addr  = mem_q.result[ADDR_W-1:0];
        pipe_hold = mem_req & ~mem_rvalid;
        timeout   = pipe_hold & (cnt_q == CNT_W'(LOAD_TIMEOUT - 1));
    end

    // Incoming EX instruction as a MEM stage entry
    always_comb begin
        ex_stage.rd     = ex_rd;
        ex_stage.we     = ex_valid & ex_we;
        ex_stage.wb_sel = ex_wb_sel;
        ex_stage.result = ex_result;
    end

    // Next-state and stage register update
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_d     = mem_q;
        err_d     = err_q;
        wb_d.rd     = mem_q.rd;
        wb_d.we     = mem_q.we;
        wb_d.result = mem_q.result;

        if (!mem_load) begin
            mem_d   = stall_in ? '0 : ex_stage;
            cnt_d   = '0;
            state_d = ST_RUN;
        end else if (mem_rvalid) begin
            // Load completes (zero-wait or after waiting)
            wb_d.we     = 1'b1;
            wb_d.result = mem_rdata;
            mem_d       = stall_in ? '0 : ex_stage;
            cnt_d       = '0;
            state_d     = ST_RUN;
        end else if (timeout) begin
            // Upstream was held this cycle, so EX is re-presented: MEM takes a bubble
            wb_d.we     = 1'b1;
            wb_d.result = '0;
            mem_d       = '0;
            err_d       = 1'b1;
            cnt_d       = '0;
            state_d     = ST_RUN;
        end else begin
            // Still waiting: hold MEM, bubble into WB
            wb_d    = '0;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = ST_WAIT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            err_q   <= err_d;
        end
    end

    assign rd_mem           = mem_q.rd;
    assign write_enable_mem = mem_q.we;
    assign wb_sel_mem       = mem_q.wb_sel;
    assign result_mem       = mem_q.result;
    assign rd_wb            = wb_q.rd;
    assign write_enable_wb  = wb_q.we;
    assign result_wb        = wb_q.result;
    assign load_error       = err_q;

endmodule

// File: tb/tb_mem_wb_forward_pipe.sv
// Self-checking bench for mem_wb_forward_pipe: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_mem_wb_forward_pipe;

    localparam int unsigned DATA_W = 256;
    localparam int unsigned TO     = 4;

    logic              clk;
    logic              rst_n;
    logic              ex_valid;
    logic              ex_we;
    logic              ex_wb_sel;
    logic [4:0]        ex_rd;
    logic [DATA_W-1:0] ex_result;
    logic              stall_in;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic [4:0]        rd_mem;
    logic              write_enable_mem;
    logic              wb_sel_mem;
    logic [DATA_W-1:0] result_mem;
    logic [4:0]        rd_wb;
    logic              write_enable_wb;
    logic [DATA_W-1:0] result_wb;
    logic              mem_req;
    logic [31:0]       mem_addr;
    logic              pipe_hold;
    logic              load_error;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    logic [4:0]        m_rd_mem, m_rd_wb;
    logic              m_we_mem, m_sel_mem, m_we_wb, m_err;
    logic [DATA_W-1:0] m_res_mem, m_res_wb;
    int                m_waits;

    mem_wb_forward_pipe #(.DATA_W(DATA_W), .LOAD_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_we(ex_we), .ex_wb_sel(ex_wb_sel),
        .ex_rd(ex_rd), .ex_result(ex_result), .stall_in(stall_in),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rd_mem(rd_mem), .write_enable_mem(write_enable_mem),
        .wb_sel_mem(wb_sel_mem), .result_mem(result_mem),
        .rd_wb(rd_wb), .write_enable_wb(write_enable_wb), .result_wb(result_wb),
        .mem_req(mem_req), .mem_addr(mem_addr), .pipe_hold(pipe_hold),
        .load_error(load_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rd_mem = '0; m_we_mem = 1'b0; m_sel_mem = 1'b0; m_res_mem = '0;
        m_rd_wb  = '0; m_we_wb  = 1'b0; m_res_wb  = '0;
        m_err    = 1'b0; m_waits = 0;
    endtask

    task automatic mem_take_ex();
        if (stall_in) begin
            m_rd_mem = '0; m_we_mem = 1'b0; m_sel_mem = 1'b0; m_res_mem = '0;
        end else begin
            m_rd_mem = ex_rd; m_we_mem = ex_valid & ex_we;
            m_sel_mem = ex_wb_sel; m_res_mem = ex_result;
        end
    endtask

    // One clock of the pipeline, expressed from the stage rules
    task automatic model_step();
        bit is_load;
        if (!rst_n) begin
            model_reset();
            return;
        end
        is_load = m_we_mem && !m_sel_mem;
        if (!is_load || mem_rvalid) begin
            m_rd_wb  = m_rd_mem;
            m_we_wb  = m_we_mem;
            m_res_wb = is_load ? mem_rdata : m_res_mem;
            m_waits  = 0;
            mem_take_ex();
        end else if (m_waits + 1 == int'(TO)) begin
            m_rd_wb = m_rd_mem; m_we_wb = 1'b1; m_res_wb = '0;
            m_rd_mem = '0; m_we_mem = 1'b0; m_sel_mem = 1'b0; m_res_mem = '0;
            m_err   = 1'b1;
            m_waits = 0;
        end else begin
            m_rd_wb = '0; m_we_wb = 1'b0; m_res_wb = '0;
            m_waits++;
        end
    endtask

    task automatic compare_all();
        logic exp_req;
        exp_req = m_we_mem & ~m_sel_mem;
        chk("rd_mem", 256'(rd_mem), 256'(m_rd_mem));
        chk("write_enable_mem", 256'(write_enable_mem), 256'(m_we_mem));
        chk("wb_sel_mem", 256'(wb_sel_mem), 256'(m_sel_mem));
        chk("result_mem", result_mem, m_res_mem);
        chk("rd_wb", 256'(rd_wb), 256'(m_rd_wb));
        chk("write_enable_wb", 256'(write_enable_wb), 256'(m_we_wb));
        chk("result_wb", result_wb, m_res_wb);
        chk("mem_req", 256'(mem_req), 256'(exp_req));
        if (exp_req) chk("mem_addr", 256'(mem_addr), 256'(m_res_mem[31:0]));
        chk("pipe_hold", 256'(pipe_hold), 256'(exp_req & ~mem_rvalid));
        chk("load_error", 256'(load_error), 256'(m_err));
    endtask

    // Compare at the falling edge, advance the model at the rising edge
    task automatic cycle();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic ex_idle();
        ex_valid = 1'b0; ex_we = 1'b0; ex_wb_sel = 1'b0; ex_rd = '0; ex_result = '0;
        stall_in = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    task automatic ex_alu(input logic [4:0] rd, input logic [31:0] val);
        ex_valid = 1'b1; ex_we = 1'b1; ex_wb_sel = 1'b1; ex_rd = rd; ex_result = 256'(val);
    endtask

    task automatic ex_load(input logic [4:0] rd, input logic [31:0] addr);
        ex_valid = 1'b1; ex_we = 1'b1; ex_wb_sel = 1'b0; ex_rd = rd; ex_result = 256'(addr);
    endtask

    function automatic logic [DATA_W-1:0] rnd_data();
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, " rd_mem"}, 256'(rd_mem), 256'h0);
        chk({tag, " we_mem"}, 256'(write_enable_mem), 256'h0);
        chk({tag, " wb_sel_mem"}, 256'(wb_sel_mem), 256'h0);
        chk({tag, " result_mem"}, result_mem, 256'h0);
        chk({tag, " rd_wb"}, 256'(rd_wb), 256'h0);
        chk({tag, " we_wb"}, 256'(write_enable_wb), 256'h0);
        chk({tag, " result_wb"}, result_wb, 256'h0);
        chk({tag, " mem_req"}, 256'(mem_req), 256'h0);
        chk({tag, " mem_addr"}, 256'(mem_addr), 256'h0);
        chk({tag, " pipe_hold"}, 256'(pipe_hold), 256'h0);
        chk({tag, " load_error"}, 256'(load_error), 256'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        ex_idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;

        // ALU op forwarding: EX -> MEM -> WB
        ex_alu(5'd3, 32'hAB);
        cycle();
        ex_idle();
        chk("alu rd_mem", 256'(rd_mem), 256'd3);
        chk("alu result_mem", result_mem, 256'hAB);
        chk("alu we_mem", 256'(write_enable_mem), 256'd1);
        cycle();
        chk("alu rd_wb", 256'(rd_wb), 256'd3);
        chk("alu result_wb", result_wb, 256'hAB);
        chk("alu we_wb", 256'(write_enable_wb), 256'd1);

        // Load with three wait cycles
        ex_load(5'd5, 32'h40);
        cycle();
        ex_idle();
        #1;
        chk("ld3 mem_req", 256'(mem_req), 256'd1);
        chk("ld3 mem_addr", 256'(mem_addr), 256'h40);
        for (int i = 0; i < 3; i++) begin
            chk("ld3 pipe_hold", 256'(pipe_hold), 256'd1);
            cycle();
            chk("ld3 wb bubble", 256'(write_enable_wb), 256'd0);
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 256'h1234;
        #1;
        chk("ld3 hold released", 256'(pipe_hold), 256'd0);
        chk("ld3 req on rvalid", 256'(mem_req), 256'd1);
        cycle();
        ex_idle();
        chk("ld3 rd_wb", 256'(rd_wb), 256'd5);
        chk("ld3 we_wb", 256'(write_enable_wb), 256'd1);
        chk("ld3 result_wb", result_wb, 256'h1234);
        chk("ld3 load_error", 256'(load_error), 256'd0);

        // Single stall pulse bubbles MEM for one cycle while WB advances
        ex_alu(5'd7, 32'h77);
        cycle();
        ex_alu(5'd9, 32'h99);
        stall_in = 1'b1;
        cycle();
        stall_in = 1'b0;
        chk("stall we_mem", 256'(write_enable_mem), 256'd0);
        chk("stall rd_mem", 256'(rd_mem), 256'd0);
        chk("stall rd_wb", 256'(rd_wb), 256'd7);
        chk("stall we_wb", 256'(write_enable_wb), 256'd1);
        cycle();
        ex_idle();
        chk("post-stall rd_mem", 256'(rd_mem), 256'd9);
        chk("post-stall we_mem", 256'(write_enable_mem), 256'd1);
        chk("post-stall we_wb", 256'(write_enable_wb), 256'd0);
        cycle();

        // Timeout after TO waiting cycles
        ex_load(5'd6, 32'h80);
        cycle();
        ex_idle();
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("to bubble", 256'(write_enable_wb), 256'd0);
            chk("to no error yet", 256'(load_error), 256'd0);
        end
        cycle();
        chk("to we_wb", 256'(write_enable_wb), 256'd1);
        chk("to rd_wb", 256'(rd_wb), 256'd6);
        chk("to result_wb", result_wb, 256'h0);
        chk("to load_error", 256'(load_error), 256'd1);
        chk("to req dropped", 256'(mem_req), 256'd0);
        repeat (3) cycle();
        chk("to sticky", 256'(load_error), 256'd1);

        // Zero-wait load with a simultaneous stall
        ex_load(5'd10, 32'hC0);
        cycle();
        ex_alu(5'd11, 32'hBB);
        stall_in   = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 256'h5555;
        #1;
        chk("zw pipe_hold", 256'(pipe_hold), 256'd0);
        chk("zw mem_req", 256'(mem_req), 256'd1);
        cycle();
        ex_idle();
        #1;
        chk("zw rd_wb", 256'(rd_wb), 256'd10);
        chk("zw we_wb", 256'(write_enable_wb), 256'd1);
        chk("zw result_wb", result_wb, 256'h5555);
        chk("zw we_mem", 256'(write_enable_mem), 256'd0);
        chk("zw rd_mem", 256'(rd_mem), 256'd0);
        chk("zw no wait", 256'(mem_req), 256'd0);

        // Asynchronous reset in the middle of a wait
        ex_load(5'd12, 32'h100);
        cycle();
        ex_idle();
        cycle();
        chk("rstw mem_req", 256'(mem_req), 256'd1);
        chk("rstw pipe_hold", 256'(pipe_hold), 256'd1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("async reset");
        model_reset();
        cycle();
        rst_n = 1'b1;
        ex_alu(5'd1, 32'h11);
        cycle();
        ex_idle();
        cycle();
        chk("post-reset rd_wb", 256'(rd_wb), 256'd1);
        chk("post-reset we_wb", 256'(write_enable_wb), 256'd1);
        chk("post-reset result_wb", result_wb, 256'h11);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            ex_valid   = 1'($urandom_range(0, 9) < 8);
            ex_we      = 1'($urandom_range(0, 9) < 8);
            ex_wb_sel  = 1'($urandom_range(0, 9) < 6);
            ex_rd      = 5'($urandom);
            ex_result  = rnd_data();
            stall_in   = 1'($urandom_range(0, 9) == 0);
            mem_rvalid = 1'($urandom_range(0, 9) < 4);
            mem_rdata  = rnd_data();
            cycle();
        end
        ex_idle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_wb_forward_pipe.md
Name: mem_wb_forward_pipe

Overview:
- Owns the EX/MEM and MEM/WB pipeline registers that feed the forwarding unit: rd, write enable, wb_sel and 256-bit result for both the MEM and WB stages.
- Inserts bubbles when the forwarding unit requests a load-use stall.
- Runs the load handshake with data memory and freezes upstream stages while a load is outstanding.
- Times out hung loads.

Parameters:
- DATA_W, 256, result width (scalar results live in bits [31:0])
- LOAD_TIMEOUT, 15, maximum wait cycles for mem_rvalid before a load is abandoned

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  EX stage holds a real instruction
- ex_we  in  1  EX instruction writes the register file
- ex_wb_sel  in  1  1 = ALU result, 0 = load result
- ex_rd  in  5  EX destination register
- ex_result  in  DATA_W  ALU result, or load address in bits [31:0]
- stall_in  in  1  load-use stall from the forwarding unit
- mem_rvalid  in  1  memory read data valid
- mem_rdata  in  DATA_W  memory read data
- rd_mem  out  5  MEM destination register
- write_enable_mem  out  1  MEM stage writes
- wb_sel_mem  out  1  MEM wb_sel
- result_mem  out  DATA_W  MEM result
- rd_wb  out  5  WB destination register
- write_enable_wb  out  1  WB stage writes
- result_wb  out  DATA_W  WB write data
- mem_req  out  1  load request to memory
- mem_addr  out  32  load address
- pipe_hold  out  1  freeze PC/IF/ID/EX
- load_error  out  1  sticky: a load timed out

Behaviour:
- Reset (async on rst_n low, release synchronous to clk):
  - all stage registers 0: rd_mem, rd_wb, write_enable_*, wb_sel_mem, result_*
  - FSM in RUN, wait counter 0, load_error 0.
- Definitions:
  - mem_load = write_enable_mem & ~wb_sel_mem.
  - FSM states: RUN and WAIT.
- RUN, mem_load = 0:
  - Each clk, MEM advances to WB: rd_wb <= rd_mem, write_enable_wb <= write_enable_mem, result_wb <= result_mem.
  - EX advances into MEM with write_enable_mem <= ex_valid & ex_we.
- stall_in = 1 (with pipe_hold = 0): MEM loads a bubble (write_enable_mem 0, rd_mem 0, result_mem 0) while MEM still advances into WB.
- Load reaches MEM (mem_load = 1):
  - mem_req = 1 combinationally; mem_addr = result_mem[31:0].
  - RUN -> WAIT is taken on the same edge unless mem_rvalid = 1 in that cycle.
  - If mem_rvalid = 1 in that cycle: zero-wait completion, the load retires like an ALU op but with result_wb <= mem_rdata.
- WAIT:
  - mem_req held at 1; pipe_hold = mem_req & ~mem_rvalid; MEM register is held.
  - WB gets a bubble each waiting cycle (write_enable_wb 0).
  - Counter increments each waiting cycle.
- mem_rvalid = 1 in WAIT:
  - WB <= {rd_mem, 1, mem_rdata}; MEM takes EX (or a bubble if stall_in); FSM -> RUN; counter cleared.
  - pipe_hold is 0 that cycle, so upstream advances.
- Timeout: counter reaches LOAD_TIMEOUT with no rvalid:
  - load retires with write_enable_wb 1 and result_wb 0; load_error set (sticky until reset); FSM -> RUN.
  - mem_req drops the following cycle.
- Priority: pipe_hold overrides stall_in. While holding, stall_in is ignored and EX is frozen upstream; it is not bubbled.
- Late rvalid: mem_rvalid while mem_load = 0 is ignored.
- Back-to-back loads: the second load enters MEM on the completion edge of the first and raises mem_req on the next cycle.
- Outputs are registered except mem_req, mem_addr and pipe_hold, which are combinational from MEM state and mem_rvalid.
- Latency: ALU op, EX to WB = 2 clks; load = 2 + wait cycles.

Test Plan:
1. Reset:
   - Stimulus: assert rst_n = 0 mid-WAIT with mem_req = 1.
   - Response: all outputs 0 immediately (asynchronous); FSM RUN after release.
2. ALU forwarding:
   - Stimulus: ex_we = 1, ex_wb_sel = 1, ex_rd = 3, ex_result = 0xAB.
   - Response: next clk rd_mem = 3, result_mem = 0xAB; following clk rd_wb = 3, result_wb = 0xAB, write_enable_wb = 1.
3. Load with 3 wait cycles:
   - Stimulus: load rd = 5, address 0x40; mem_rvalid on the 4th request cycle with rdata 0x1234.
   - Response: mem_addr = 0x40; pipe_hold high for 3 cycles; WB bubbles for 3 cycles; then rd_wb = 5, result_wb = 0x1234.
4. stall_in pulse:
   - Stimulus: one stall_in pulse with pipe_hold = 0.
   - Response: MEM shows write_enable_mem = 0, rd_mem = 0 for exactly one cycle; WB still advances.
5. Timeout:
   - Stimulus: LOAD_TIMEOUT = 4, mem_rvalid never asserted.
   - Response: after 4 wait cycles load_error = 1 and write_enable_wb = 1 with result_wb = 0; load_error persists until reset.
6. Zero-wait load plus simultaneous stall:
   - Stimulus: zero-wait load (rvalid in the request cycle) with stall_in = 1 in the same cycle.
   - Response: no WAIT entry; pipe_hold stays 0; WB gets the load data; MEM gets a bubble.
